// File: rtl/plane_ray_result_rob_if.sv
// Bundle of the allocate, writeback, release and status signals of the ray-plane result buffer.
// Latency: none; this file only carries wires.
// Backpressure: alloc_ready_o throttles allocation; out_ready_i stalls release.
interface plane_ray_result_rob_if #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2
);
    logic                     flush_i;
    logic                     alloc_valid_i;
    logic                     alloc_ready_o;
    logic [TAG_W-1:0]         alloc_tag_o;
    logic [NUM_CH-1:0]        res_valid_i;
    logic [NUM_CH*TAG_W-1:0]  res_tag_i;
    logic [NUM_CH*DATA_W-1:0] res_data_i;
    logic [NUM_CH*5-1:0]      res_status_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [TAG_W-1:0]         out_tag_o;
    logic [DATA_W-1:0]        out_data_o;
    logic [4:0]               out_status_o;
    logic [TAG_W:0]           count_o;
    logic                     err_o;

    // Issue side and consumer: drives requests, writebacks and ready.
    modport master (
        output flush_i, alloc_valid_i, res_valid_i, res_tag_i, res_data_i, res_status_i, out_ready_i,
        input  alloc_ready_o, alloc_tag_o, out_valid_o, out_tag_o, out_data_o, out_status_o, count_o, err_o
    );

    // The reorder buffer itself.
    modport slave (
        input  flush_i, alloc_valid_i, res_valid_i, res_tag_i, res_data_i, res_status_i, out_ready_i,
        output alloc_ready_o, alloc_tag_o, out_valid_o, out_tag_o, out_data_o, out_status_o, count_o, err_o
    );
endinterface

// File: rtl/plane_ray_result_rob.sv
// In-order result buffer: tags FPU ops, takes out-of-order writebacks, releases in tag order.
// Latency: writeback at edge N is releasable in the cycle after N; no res_* to out_* comb path.
// Backpressure: out_* held stable while out_ready_i low; allocation stalls when full. Option macro: PLANE_RAY_ROB_STATUS_EN.
module plane_ray_result_rob #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    plane_ray_result_rob_if.slave bus
);
    localparam int DEPTH = 1 << TAG_W;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [TAG_W:0]   ptr_t;

    ptr_t              head_q;
    ptr_t              tail_q;
    ptr_t              count;
    tag_t              head_idx;
    tag_t              tail_idx;
    logic [DEPTH-1:0]  alloc_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  alloc_d;
    logic [DEPTH-1:0]  done_d;
    logic              err_q;
    logic [DATA_W-1:0] data_q [DEPTH];
    tag_t              wb_tag [NUM_CH];
    logic [NUM_CH-1:0] wb_ok;
    logic              wb_err;
    logic              alloc_fire;
    logic              rel_fire;
    logic              out_vld;

    // Pointers carry one extra bit so a full buffer is distinguishable from an empty one.
    assign count      = tail_q - head_q;
    assign head_idx   = head_q[TAG_W-1:0];
    assign tail_idx   = tail_q[TAG_W-1:0];
    assign out_vld    = alloc_q[head_idx] && done_q[head_idx];

    // Ready depends on registered count only, so a same-cycle release never unblocks a full buffer.
    assign bus.alloc_ready_o = (count != ptr_t'(DEPTH));
    assign alloc_fire        = bus.alloc_valid_i && bus.alloc_ready_o && !bus.flush_i;
    assign rel_fire          = out_vld && bus.out_ready_i && !bus.flush_i;

    // Qualify each writeback channel; the lowest channel wins a tag collision.
    always_comb begin
        wb_ok  = '0;
        wb_err = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            wb_tag[k] = bus.res_tag_i[k*TAG_W +: TAG_W];
        end
        for (int k = 0; k < NUM_CH; k++) begin
            wb_ok[k] = bus.res_valid_i[k] && alloc_q[wb_tag[k]] && !done_q[wb_tag[k]]
                       && !(alloc_fire && (wb_tag[k] == tail_idx));
            for (int j = 0; j < k; j++) begin
                if (bus.res_valid_i[j] && (wb_tag[j] == wb_tag[k])) begin
                    wb_ok[k] = 1'b0;
                end
            end
            wb_err = wb_err || (bus.res_valid_i[k] && !wb_ok[k]);
        end
    end

    // Next per-entry alloc/done bits from release, allocation and accepted writebacks.
    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q;
        if (rel_fire) begin
            alloc_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
        end
        if (alloc_fire) begin
            alloc_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (wb_ok[k]) begin
                done_d[wb_tag[k]] = 1'b1;
            end
        end
    end

    // Control state; flush wipes entries and pointers but keeps the sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else if (bus.flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            done_q  <= '0;
        end else begin
            alloc_q <= alloc_d;
            done_q  <= done_d;
            err_q   <= err_q || wb_err;
            if (alloc_fire) begin
                tail_q <= tail_q + ptr_t'(1);
            end
            if (rel_fire) begin
                head_q <= head_q + ptr_t'(1);
            end
        end
    end

    // Result payload storage; only read behind done bits, so no reset is needed.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (wb_ok[k] && !bus.flush_i) begin
                data_q[wb_tag[k]] <= bus.res_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef PLANE_RAY_ROB_STATUS_EN
    logic [4:0] status_q [DEPTH];

    // fpnew status flags stored alongside the result.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (wb_ok[k] && !bus.flush_i) begin
                status_q[wb_tag[k]] <= bus.res_status_i[k*5 +: 5];
            end
        end
    end

    assign bus.out_status_o = out_vld ? status_q[head_idx] : 5'd0;
`else
    logic unused_status;
    assign unused_status    = ^bus.res_status_i;
    assign bus.out_status_o = 5'd0;
`endif

    assign bus.alloc_tag_o = tail_idx;
    assign bus.out_valid_o = out_vld;
    assign bus.out_tag_o   = out_vld ? head_idx : '0;
    assign bus.out_data_o  = out_vld ? data_q[head_idx] : '0;
    assign bus.count_o     = count;
    assign bus.err_o       = err_q;
endmodule

// File: doc/plane_ray_result_rob.md
# plane_ray_result_rob

Parametrised in-order result buffer for the ray-plane intersection datapath. Allocates tags (`tag_t`-style, `TAG_W` bits) to operations issued into the FPU slices and accepts their out-of-order writebacks on `NUM_CH` independent result channels. The default is 2 channels: channel 0 is the 2-cycle FMA slice and channel 1 is the 4-cycle divider. Results are released strictly in allocation order through a valid/ready port, which removes the fixed single-unit latency assumption of the first-generation FPU configuration.

## Interface
Parameters:
- `TAG_W`, 5: tag width; buffer depth `DEPTH = 2**TAG_W`.
- `DATA_W`, 32: result width (FP32).
- `NUM_CH`, 2: number of writeback channels.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  synchronous clear of all entries. Has priority over every other input in the same cycle.
- `alloc_valid_i`  in  1  request for a new tag.
- `alloc_ready_o`  out  1  a free entry exists.
- `alloc_tag_o`  out  TAG_W  tag granted on handshake.
- `res_valid_i`  in  NUM_CH  per-channel writeback strobe.
- `res_tag_i`  in  NUM_CH*TAG_W  per-channel tag; channel k occupies bits [k*TAG_W +: TAG_W].
- `res_data_i`  in  NUM_CH*DATA_W  per-channel result.
- `res_status_i`  in  NUM_CH*5  per-channel fpnew status flags (NV, DZ, OF, UF, NX).
- `out_valid_o`  out  1  oldest entry is complete.
- `out_ready_i`  in  1  consumer accepts.
- `out_tag_o`  out  TAG_W  tag of the released result.
- `out_data_o`  out  DATA_W  released result.
- `out_status_o`  out  5  released status flags.
- `count_o`  out  TAG_W+1  number of allocated entries.
- `err_o`  out  1  sticky protocol error flag.

## Operation
- **State**
  - `head` and `tail` pointers are each TAG_W+1 bits; the MSB distinguishes full from empty.
  - Each entry holds `alloc` and `done` bits plus data and status.
  - `count = tail - head`, computed modulo 2**(TAG_W+1).
- **Allocate**
  - `alloc_ready_o = (count != DEPTH)`.
  - `alloc_tag_o = tail[TAG_W-1:0]`.
  - On `alloc_valid_i && alloc_ready_o`: set `alloc[tag]`, clear `done[tag]`, increment `tail`.
- **Writeback (per channel k)**
  - A writeback is legal when `res_valid_i[k]`, `alloc[tag]` is set and `done[tag]` is clear. A legal writeback stores data and status and sets `done`.
  - Illegal writebacks are dropped and set `err_o`. Illegal cases are: unallocated tag, already-done tag, or a tag being allocated in the same cycle.
  - Two channels writing the same tag in one cycle: the lowest channel index wins, the others are dropped, and `err_o` is set.
- **Release**
  - `out_valid_o = alloc[head] && done[head]`.
  - On `out_valid_o && out_ready_i`: clear `alloc` and `done` for the head entry and increment `head`.
  - `out_tag_o`, `out_data_o` and `out_status_o` are forced to 0 whenever `out_valid_o` is low.
- **Simultaneous events**
  - Allocate and release in the same cycle are both allowed; `count` is unchanged.
  - When full, allocation is blocked even if a release occurs in the same cycle. There is no pass-through.
- **Flush**
  - Clears all `alloc` and `done` bits and sets `head = tail = 0`.
  - `err_o` is preserved.
  - Allocations, writebacks and releases presented in the flush cycle are ignored.
- **Clearing the error flag**: `err_o` clears only on `rst_i`.

## Timing
- **Reset values**
  - `alloc_ready_o` = 1.
  - `alloc_tag_o` = 0.
  - `out_valid_o` = 0.
  - `out_tag_o`, `out_data_o`, `out_status_o` = 0.
  - `count_o` = 0.
  - `err_o` = 0.
- **Reset mid-operation**: asserting `rst_i` immediately and asynchronously clears pointers and `alloc`/`done` bits; any in-flight writebacks are lost.
- **Writeback to release**: a writeback accepted at edge N can be released at the head with `out_valid_o` high in the cycle after edge N (1-cycle latency). There is no combinational path from `res_*` to `out_*`.
- **Allocate to writeback**: a tag allocated at edge N may be written back from the cycle after edge N.
- **Ready timing**: `alloc_ready_o` and `out_valid_o` are functions of registered state only.
- **Backpressure**: `out_valid_o` and the `out_*` fields hold stable while `out_ready_i` is low.

## Configuration
- Macro: `PLANE_RAY_ROB_STATUS_EN`.
- **Defined**: 5-bit status is stored per entry and returned on `out_status_o`.
- **Undefined**:
  - No status storage is built.
  - `res_status_i` is ignored.
  - `out_status_o` is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- **Reorder**: allocate tags 0, 1, 2. Write back on ch1 tag 2 = 0x40400000, then ch0 tag 0 = 0x3F800000, then ch0 tag 1 = 0x40000000. Outputs must appear in order 0, 1, 2 with those data; `count_o` goes 3 → 0.
- **Full**: 32 allocations with no writeback → `alloc_ready_o` = 0 and `count_o` = 32. One writeback and release of tag 0 → `alloc_ready_o` = 1 and the next tag granted is 0.
- **Errors**:
  - Writeback of an unallocated tag 7 → `err_o` = 1 and no state change.
  - Same tag on ch0 and ch1 in one cycle → the ch0 data is released and `err_o` = 1.
- **Backpressure**: hold `out_ready_i` = 0 for 5 cycles with head done → `out_*` stable. A release coincident with an allocation leaves `count_o` unchanged.
- **Flush and reset**:
  - Flush with 4 entries outstanding → `count_o` = 0, next tag = 0, `err_o` unchanged.
  - Async `rst_i` pulse between clock edges → all outputs at reset values before the next edge.
- **Status (macro defined)**: ch1 status 0b01000 (DZ) on tag 0 → `out_status_o` = 0b01000. With the macro undefined → `out_status_o` = 0.
